xbar_config_ctl: RTL and testbench
==================================

XBAR_CONFIG_CTL -- requirements
Module: xbar_config_ctl

Interface
REQ-001 Parameter: BLANK_CYCLES, default 4, number of cycles the crossbar stays gated after a selector change; legal range 1..15.
REQ-002 clk_in  input  1  sole clock; all logic on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 cfg_valid_in  input  1  new configuration offered.
REQ-005 cfg_sel_in  input  8  requested selectors: [1:0]=input a, [3:2]=b, [5:4]=c, [7:6]=d; value = destination output index.
REQ-006 cfg_ready_out  output  1  controller accepts cfg_valid_in this cycle.
REQ-007 cfg_abort_in  input  1  cancel a pending configuration still waiting for frame sync.
REQ-008 frame_sync_in  input  1  one-cycle pulse marking a frame boundary.
REQ-009 xbar_selectors_a/_b/_c/_d  output  2 each  registered selectors driven to the 4x4 crossbar.
REQ-010 xbar_enable_out  output  1  output gate for crossbar consumers; 0 = outputs blanked.
REQ-011 cfg_busy_out  output  1  high in any state other than IDLE.
REQ-012 cfg_done_out  output  1  one-cycle pulse: configuration applied or no-op accepted.
REQ-013 cfg_err_out  output  1  one-cycle pulse: configuration rejected.

Function
REQ-014 FSM states: IDLE, CHECK, WAIT_SYNC, GATE, BLANK.
REQ-015 IDLE: cfg_ready_out=1; on cfg_valid_in=1, capture cfg_sel_in into pending register and go to CHECK. cfg_ready_out=0 in all other states; cfg_valid_in ignored there.
REQ-016 CHECK (exactly 1 cycle): pending is legal only if its four 2-bit fields are pairwise distinct (a permutation).
REQ-017 CHECK, illegal: pulse cfg_err_out the following cycle, return to IDLE, selectors unchanged.
REQ-018 CHECK, legal and equal to current selectors: pulse cfg_done_out the following cycle, return to IDLE, no gating.
REQ-019 CHECK, legal and different: go to WAIT_SYNC; frame_sync_in asserted during CHECK is ignored.
REQ-020 WAIT_SYNC: on frame_sync_in=1 go to GATE; on cfg_abort_in=1 return to IDLE with no output change and no done/err pulse; if both are asserted in the same cycle, abort wins.
REQ-021 With sync sampled at cycle t: xbar_enable_out=0 from t+1 (GATE, old selectors still driven); selectors take pending value at t+2 (first BLANK cycle).
REQ-022 BLANK lasts BLANK_CYCLES cycles (t+2 .. t+1+BLANK_CYCLES); at t+2+BLANK_CYCLES: xbar_enable_out=1, cfg_done_out pulse, state IDLE, cfg_ready_out=1.
REQ-023 Selectors never change while xbar_enable_out=1; xbar_enable_out changes only on GATE entry and BLANK exit.
REQ-024 frame_sync_in and cfg_abort_in are ignored in IDLE, CHECK, GATE and BLANK.
REQ-025 Blank counter is 4 bits and wraps never; it is loaded on GATE entry and does not decrement outside BLANK.
REQ-026 cfg_done_out and cfg_err_out are never both high; each is high for exactly one cycle per request.

Reset
REQ-027 While rst_in=1 at a clock edge: state IDLE; selectors a=00, b=01, c=10, d=11 (identity); xbar_enable_out=1; cfg_ready_out=1; cfg_busy_out=0; cfg_done_out=0; cfg_err_out=0; pending cleared to identity.
REQ-028 Reset in any state, including GATE/BLANK, takes effect on the next edge; an in-progress configuration is discarded with no done/err pulse.

Verification
REQ-029 Reset, then cfg_sel_in=8'h1B (a=11,b=10,c=01,d=00), sync at t, BLANK_CYCLES=4 -> enable 0 at t+1..t+5, selectors 11/10/01/00 from t+2, enable 1 and done pulse at t+6.
REQ-030 cfg_sel_in=8'h00 (duplicates) -> err pulse 2 cycles after acceptance, selectors remain identity, enable never drops.
REQ-031 cfg_sel_in=8'hE4 (identity) after reset -> done pulse 2 cycles after acceptance, no gating, no sync needed.
REQ-032 Legal config, then cfg_abort_in and frame_sync_in asserted together in WAIT_SYNC -> IDLE next cycle, selectors unchanged, no done/err pulse.
REQ-033 rst_in asserted during the third BLANK cycle -> next cycle selectors identity, enable 1, ready 1, no done pulse.
REQ-034 cfg_valid_in held high with varying cfg_sel_in while busy -> only the value present at acceptance in IDLE is applied.

Source files
------------

// File: rtl/xbar_config_ctl.sv
// Configuration controller for a 4x4 crossbar: validates a requested selector
// permutation, waits for a frame boundary, then blanks the outputs around the switch.
module xbar_config_ctl #(
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       cfg_valid_in,
  input  logic [7:0] cfg_sel_in,
  output logic       cfg_ready_out,
  input  logic       cfg_abort_in,
  input  logic       frame_sync_in,
  output logic [1:0] xbar_selectors_a,
  output logic [1:0] xbar_selectors_b,
  output logic [1:0] xbar_selectors_c,
  output logic [1:0] xbar_selectors_d,
  output logic       xbar_enable_out,
  output logic       cfg_busy_out,
  output logic       cfg_done_out,
  output logic       cfg_err_out
);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT_SYNC, GATE, BLANK} state_t;

  localparam logic [7:0] IDENTITY   = 8'hE4;
  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES);

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] sel_reg, sel_next;
  logic [3:0] count_reg, count_next;
  logic       enable_reg, enable_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  // Each field marks the output it claims; a permutation claims all four.
  logic [3:0] field_hit [4];
  logic       pending_legal;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      assign field_hit[gi] = 4'b0001 << pending_reg[2*gi +: 2];
    end
  endgenerate

  assign pending_legal = &(field_hit[0] | field_hit[1] | field_hit[2] | field_hit[3]);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      pending_reg <= IDENTITY;
      sel_reg     <= IDENTITY;
      count_reg   <= 4'd0;
      enable_reg  <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      count_reg   <= count_next;
      enable_reg  <= enable_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    sel_next     = sel_reg;
    count_next   = count_reg;
    enable_next  = enable_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_valid_in) begin
          pending_next = cfg_sel_in;
          state_next   = CHECK;
        end
      end
      CHECK: begin
        if (!pending_legal) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (pending_reg == sel_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        // Abort takes priority over a coincident frame boundary.
        if (cfg_abort_in) begin
          state_next = IDLE;
        end else if (frame_sync_in) begin
          enable_next = 1'b0;
          count_next  = BLANK_LOAD;
          state_next  = GATE;
        end
      end
      GATE: begin
        sel_next   = pending_reg;
        state_next = BLANK;
      end
      BLANK: begin
        if (count_reg <= 4'd1) begin
          enable_next = 1'b1;
          done_next   = 1'b1;
          state_next  = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cfg_ready_out    = (state_reg == IDLE);
  assign cfg_busy_out     = (state_reg != IDLE);
  assign cfg_done_out     = done_reg;
  assign cfg_err_out      = err_reg;
  assign xbar_enable_out  = enable_reg;
  assign xbar_selectors_a = sel_reg[1:0];
  assign xbar_selectors_b = sel_reg[3:2];
  assign xbar_selectors_c = sel_reg[5:4];
  assign xbar_selectors_d = sel_reg[7:6];

endmodule

// File: tb/tb_xbar_config_ctl.sv
// Directed bench for xbar_config_ctl: stimulus schedules expected per-cycle
// outputs into a queue; a negedge monitor pops and compares them.
module tb_xbar_config_ctl;

  logic       clk = 1'b0;
  logic       rst, valid, abort, sync;
  logic [7:0] sel;
  logic       ready, enable, busy, done, err;
  logic [1:0] sa, sb_o, sc, sd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    string      tag;
    logic [7:0] s;
    logic       en;
    logic       dn;
    logic       er;
    logic       bz;
  } exp_t;

  exp_t sbq [$];

  xbar_config_ctl #(.BLANK_CYCLES(4)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .cfg_valid_in(valid),
    .cfg_sel_in(sel),
    .cfg_ready_out(ready),
    .cfg_abort_in(abort),
    .frame_sync_in(sync),
    .xbar_selectors_a(sa),
    .xbar_selectors_b(sb_o),
    .xbar_selectors_c(sc),
    .xbar_selectors_d(sd),
    .xbar_enable_out(enable),
    .cfg_busy_out(busy),
    .cfg_done_out(done),
    .cfg_err_out(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s cyc=%0d observed=%h expected=%h", tag, what, cyc, obs, expv);
    end
  endtask

  task automatic push(input int at, input string tag, input logic [7:0] s,
                      input logic en, input logic dn, input logic er, input logic bz);
    exp_t e;
    e.at = at; e.tag = tag; e.s = s; e.en = en; e.dn = dn; e.er = er; e.bz = bz;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, "cycle", 8'(cyc - e.at), 8'd0);
      chk(e.tag, "sel", {sd, sc, sb_o, sa}, e.s);
      chk(e.tag, "enable", {7'd0, enable}, {7'd0, e.en});
      chk(e.tag, "done", {7'd0, done}, {7'd0, e.dn});
      chk(e.tag, "err", {7'd0, err}, {7'd0, e.er});
      chk(e.tag, "busy", {7'd0, busy}, {7'd0, e.bz});
      chk(e.tag, "ready", {7'd0, ready}, {7'd0, ~e.bz});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    rst = 1'b1; valid = 1'b0; sel = 8'h00; abort = 1'b0; sync = 1'b0;

    // Reset state
    tick();
    push(cyc + 1, "reset", 8'hE4, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Identity request after reset: no-op done, no gating
    n = cyc; valid = 1'b1; sel = 8'hE4;
    push(n + 1, "noop_check", 8'hE4, 1, 0, 0, 1);
    push(n + 2, "noop_done",  8'hE4, 1, 1, 0, 0);
    push(n + 3, "noop_after", 8'hE4, 1, 0, 0, 0);
    tick(); valid = 1'b0;
    tick(); tick();

    // Duplicate fields: rejected
    n = cyc; valid = 1'b1; sel = 8'h00;
    push(n + 1, "err_check", 8'hE4, 1, 0, 0, 1);
    push(n + 2, "err_pulse", 8'hE4, 1, 0, 1, 0);
    push(n + 3, "err_after", 8'hE4, 1, 0, 0, 0);
    tick(); valid = 1'b0;
    tick(); tick();

    // Full reconfiguration to 1B; valid held with changing data, sync during CHECK ignored
    n = cyc; valid = 1'b1; sel = 8'h1B; sync = 1'b1;
    push(n + 1, "main_check", 8'hE4, 1, 0, 0, 1);
    push(n + 2, "main_wait",  8'hE4, 1, 0, 0, 1);
    push(n + 3, "main_wait2", 8'hE4, 1, 0, 0, 1);
    tick(); sel = 8'h00; sync = 1'b1;
    tick(); sel = 8'h4E; sync = 1'b0;
    tick(); sel = 8'h39; sync = 1'b1;
    m = cyc;
    push(m + 1, "main_gate", 8'hE4, 0, 0, 0, 1);
    for (int k = 2; k <= 5; k++) push(m + k, "main_blank", 8'h1B, 0, 0, 0, 1);
    push(m + 6, "main_done", 8'h1B, 1, 1, 0, 0);
    push(m + 7, "main_idle", 8'h1B, 1, 0, 0, 0);
    tick(); sync = 1'b0; sel = 8'hB1;
    tick(); sel = 8'hE4;
    tick(); sel = 8'h93;
    tick(); sel = 8'h4E;
    tick(); sel = 8'h27;
    tick(); valid = 1'b0;
    tick(); tick();

    // Abort and sync together in WAIT_SYNC: abort wins
    n = cyc; valid = 1'b1; sel = 8'h4E;
    push(n + 1, "abort_check", 8'h1B, 1, 0, 0, 1);
    push(n + 2, "abort_wait",  8'h1B, 1, 0, 0, 1);
    push(n + 3, "abort_idle",  8'h1B, 1, 0, 0, 0);
    push(n + 4, "abort_quiet", 8'h1B, 1, 0, 0, 0);
    tick(); valid = 1'b0;
    tick(); abort = 1'b1; sync = 1'b1;
    tick(); abort = 1'b0; sync = 1'b0;
    tick(); tick();

    // Reset during the third BLANK cycle discards the configuration
    n = cyc; valid = 1'b1; sel = 8'h4E;
    push(n + 1, "rb_check", 8'h1B, 1, 0, 0, 1);
    push(n + 2, "rb_wait",  8'h1B, 1, 0, 0, 1);
    tick(); valid = 1'b0;
    tick(); sync = 1'b1;
    m = cyc;
    push(m + 1, "rb_gate", 8'h1B, 0, 0, 0, 1);
    for (int k = 2; k <= 4; k++) push(m + k, "rb_blank", 8'h4E, 0, 0, 0, 1);
    push(m + 5, "rb_reset", 8'hE4, 1, 0, 0, 0);
    push(m + 6, "rb_after", 8'hE4, 1, 0, 0, 0);
    push(m + 7, "rb_quiet", 8'hE4, 1, 0, 0, 0);
    tick(); sync = 1'b0;
    tick(); tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick(); tick();
    tick();

    chk("scoreboard", "leftover", 8'(sbq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
